bsg_fifo_rr_burst_sched: RTL and testbench
==========================================

# bsg_fifo_rr_burst_sched

Round-robin scheduler that drains `els_p` independent small FIFOs (each exposing valid-yumi outputs) into one registered valid-ready output stream. A grant may be held for up to `burst_p` consecutive dequeues from the same FIFO before the pointer rotates. It sits between a bank of `bsg_fifo_1r1w_small` instances and a shared downstream consumer, such as a network injection port or a memory request channel. Each output word carries the index of its source FIFO.

## Interface
- `width_p`, default 32: data width per FIFO.
- `els_p`, default 4: number of source FIFOs. Must be ≥2.
- `burst_p`, default 4: maximum consecutive grants to one source. Must be ≥1; a value of 1 gives pure round-robin.
- `clk_i`, input, 1: the single clock.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `v_i`, input, `els_p`: per-FIFO valid.
- `data_i`, input, `els_p*width_p`: per-FIFO data. FIFO k occupies bits `[k*width_p +: width_p]`.
- `yumi_o`, output, `els_p`: per-FIFO dequeue. Zero-hot or one-hot.
- `v_o`, output, 1: output register valid.
- `data_o`, output, `width_p`: output register data.
- `tag_o`, output, `$clog2(els_p)`: source index of `data_o`.
- `ready_i`, input, 1: downstream ready. A transfer occurs when `v_o & ready_i`.

## Operation
- **State:**
  - `owner_r`: index of the last granted source.
  - `lock_r`: burst lock flag.
  - `cnt_r`: grants in the current burst, width `$clog2(burst_p+1)`.
  - Output register `{v_o, data_o, tag_o}`.
- **Load opportunity:** `load = ~v_o | ready_i`.
- **Grant selection**, evaluated only when `load` is 1 and `|v_i` is 1:
  - If `lock_r` is 1 and `v_i[owner_r]` is 1, then `sel = owner_r`.
  - Otherwise `sel` is the first set `v_i` searching `owner_r+1, owner_r+2, …` modulo `els_p`, ending at `owner_r`. The last owner therefore has the lowest priority.
- **Dequeue:** `yumi_o = onehot(sel)` when `load & |v_i`, otherwise 0. `yumi_o` is combinational from `v_i`, `v_o`, `ready_i` and state. It never asserts for a source whose `v_i` is 0.
- **On a grant:**
  - `data_o <= data_i[sel]`, `tag_o <= sel`, `v_o <= 1`.
  - `cnt_n = (lock_r & sel==owner_r) ? cnt_r+1 : 1`.
  - `owner_r <= sel`, `cnt_r <= cnt_n`, `lock_r <= (cnt_n < burst_p)`.
- **On `load` with no valid source:**
  - `v_o <= 0`.
  - `owner_r`, `lock_r` and `cnt_r` are unchanged, so the lock survives idle cycles.
- **On stall** (`v_o & ~ready_i`):
  - The output register and all state are held.
  - `yumi_o` is 0.
- **Lock release:** the lock ends under either of these conditions:
  - `cnt_r` reaches `burst_p`.
  - The owner is not valid at a grant opportunity while another source is. Any new grant to a different source resets `cnt` to 1.
- **Reset values** (asynchronous, while `reset_n_i` is 0):
  - `v_o` = 0, `data_o` = 0, `tag_o` = 0.
  - `owner_r = els_p-1`, so source 0 has first priority; `lock_r` = 0, `cnt_r` = 0.
  - `yumi_o` is forced to 0.
- **Mid-operation reset:** any word held in the output register is discarded. Already-dequeued data is not recovered, because source FIFOs are reset by the same signal.

## Timing
- **Latency:** 1 cycle from a `yumi_o[k]` assertion to the corresponding word appearing on `v_o`/`data_o`/`tag_o`.
- **Throughput:** one word per cycle while `ready_i` stays high and any source is valid. There are no bubbles on owner switches.
- **Backpressure:** `ready_i` low with `v_o` high produces zero `yumi_o` in that same cycle. `data_o` and `tag_o` stay stable until the transfer.
- **Reset release:** the first grant can occur in the first rising edge after `reset_n_i` deasserts.
- **Output stability:** `v_o`, `data_o` and `tag_o` are registered outputs with no combinational path from inputs.

## Test plan
- **Reset:** hold `reset_n_i` low with `v_i=4'b1111` → `yumi_o=0`, `v_o=0`, `tag_o=0`. After release with `ready_i=1`, the first grant goes to source 0.
- **Burst pattern:** `els_p=4`, `burst_p=4`, all sources always valid, `ready_i=1` → `tag_o` sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…
- **Owner drops mid-burst:** source 2 is valid for 2 words only and sources 0 and 3 are valid; expected behaviour:
  - The burst for 2 ends after those 2 words.
  - The next grant goes to 3.
  - `cnt` restarts, giving 4 grants to 3, then 0.
- **Backpressure:** toggle `ready_i` 1,0,0,1 during a burst → `yumi_o=0` on stall cycles and `data_o` is held. The total word order is identical to the unstalled run, with no drops or duplicates (scoreboard per source).
- **Pure round-robin:** `burst_p=1`, sources 1 and 3 continuously valid → `tag_o` is 1,3,1,3…
- **Asynchronous reset mid-burst:** assert `reset_n_i` low mid-cycle during the third word of a burst to source 1 → `v_o` drops immediately without a clock edge. After release, the grant restarts at source 0.

Source files
------------

// File: rtl/bsg_fifo_rr_burst_sched.sv
// bsg_fifo_rr_burst_sched: round-robin burst scheduler draining valid-yumi FIFOs into a registered valid-ready stream
module bsg_fifo_rr_burst_sched #(
  parameter int width_p = 32,
  parameter int els_p   = 4,
  parameter int burst_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic [els_p-1:0]           yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p)-1:0]   tag_o,
  input  logic                       ready_i
);
  localparam int tag_w = $clog2(els_p);
  localparam int cnt_w = $clog2(burst_p + 1);

  logic [tag_w-1:0] r_owner;
  logic             r_lock;
  logic [cnt_w-1:0] r_cnt;
  logic [tag_w-1:0] w_sel;
  logic [cnt_w-1:0] w_cnt_n;
  logic             w_load;
  logic             w_grant;

  assign w_load  = ~v_o | ready_i;
  assign w_grant = w_load & (|v_i) & reset_n_i;
  assign w_cnt_n = (r_lock && w_sel == r_owner) ? r_cnt + cnt_w'(1) : cnt_w'(1);

  // rotating search starting after the last owner; a live burst lock keeps the owner
  always_comb begin
    w_sel = r_owner;
    for (int i = els_p; i >= 1; i--)
      if (v_i[(int'(r_owner) + i) % els_p]) w_sel = tag_w'((int'(r_owner) + i) % els_p);
    if (r_lock && v_i[r_owner]) w_sel = r_owner;
  end

  // dequeue is the one-hot of the selected source, only when a word can be loaded
  always_comb begin
    yumi_o        = '0;
    yumi_o[w_sel] = w_grant;
  end

  // output register and burst state; held entirely while the consumer stalls
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o     <= 1'b0;
      data_o  <= '0;
      tag_o   <= '0;
      r_owner <= tag_w'(els_p - 1);
      r_lock  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      v_o <= |v_i;
      if (|v_i) begin
        data_o  <= data_i[w_sel*width_p +: width_p];
        tag_o   <= w_sel;
        r_owner <= w_sel;
        r_cnt   <= w_cnt_n;
        r_lock  <= w_cnt_n < cnt_w'(burst_p);
      end
    end
  end
endmodule

// File: tb/tb_bsg_fifo_rr_burst_sched.sv
// tb_bsg_fifo_rr_burst_sched: directed checks of grant order, burst lock, backpressure and reset
module tb_bsg_fifo_rr_burst_sched;
  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic [3:0]   v_i = '0, v2_i = '0;
  logic [127:0] data_i, data2_i;
  logic         ready_i = 1'b1, ready2_i = 1'b1;
  logic [3:0]   yumi_o, yumi2_o;
  logic         v_o, v2_o;
  logic [31:0]  data_o, data2_o;
  logic [1:0]   tag_o, tag2_o;
  int           total = 0;
  int           bad = 0;
  int           src_seq [4];

  localparam logic [3:0] DROP_V [7] = '{4'b0100, 4'b1101, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
  localparam logic [3:0] DROP_Y [7] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
  localparam logic [1:0] DROP_T [7] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
  localparam logic       BP_RDY [24] = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1};

  always #5 clk = ~clk;

  always_comb for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = {8'(k), 24'(src_seq[k])};
  assign data2_i = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

  bsg_fifo_rr_burst_sched #(.width_p(32), .els_p(4), .burst_p(4)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .v_o(v_o), .data_o(data_o), .tag_o(tag_o), .ready_i(ready_i)
  );

  bsg_fifo_rr_burst_sched #(.width_p(32), .els_p(4), .burst_p(1)) u_rr (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v2_i), .data_i(data2_i), .yumi_o(yumi2_o),
    .v_o(v2_o), .data_o(data2_o), .tag_o(tag2_o), .ready_i(ready2_i)
  );

  // one clock: source FIFOs advance on the yumi seen before the edge; returns at the next negedge
  task automatic edge_step();
    logic [3:0] y;
    #1 y = yumi_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (y[k]) src_seq[k]++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    for (int k = 0; k < 4; k++) src_seq[k] = 0;
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    v_i = 4'b1111;
    ready_i = 1'b1;
    @(negedge clk);
    #1;
    total++; if (yumi_o !== 4'b0000) begin bad++; $display("FAIL reset_yumi got=%b exp=%b", yumi_o, 4'b0000); end
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v got=%b exp=0", v_o); end
    total++; if (tag_o !== 2'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", tag_o); end
    total++; if (data_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    total++; if (yumi_o !== 4'b0001) begin bad++; $display("FAIL release_yumi got=%b exp=0001", yumi_o); end
    edge_step();
    total++; if (v_o !== 1'b1 || tag_o !== 2'd0) begin bad++; $display("FAIL first_grant got v=%b tag=%0d exp v=1 tag=0", v_o, tag_o); end
  endtask

  task automatic test_burst();
    int exp_tag, exp_seq;
    do_reset();
    v_i = 4'b1111;
    ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      edge_step();
      exp_tag = (i / 4) % 4;
      exp_seq = (i % 4) + 4 * (i / 16);
      total++;
      if (v_o !== 1'b1 || tag_o !== 2'(exp_tag) || data_o !== {8'(exp_tag), 24'(exp_seq)}) begin
        bad++; $display("FAIL burst[%0d] got v=%b tag=%0d data=%h exp tag=%0d data=%h", i, v_o, tag_o, data_o, exp_tag, {8'(exp_tag), 24'(exp_seq)});
      end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v_i = DROP_V[i];
      #1;
      total++; if (yumi_o !== DROP_Y[i]) begin bad++; $display("FAIL drop_yumi[%0d] got=%b exp=%b", i, yumi_o, DROP_Y[i]); end
      edge_step();
      total++; if (tag_o !== DROP_T[i]) begin bad++; $display("FAIL drop_tag[%0d] got=%0d exp=%0d", i, tag_o, DROP_T[i]); end
    end
  endtask

  task automatic test_idle_lock();
    do_reset();
    ready_i = 1'b1;
    v_i = 4'b0100;
    edge_step();
    v_i = 4'b0000;
    #1;
    total++; if (yumi_o !== 4'b0000) begin bad++; $display("FAIL idle_yumi got=%b exp=0000", yumi_o); end
    edge_step();
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL idle_v got=%b exp=0", v_o); end
    v_i = 4'b1101;
    #1;
    total++; if (yumi_o !== 4'b0100) begin bad++; $display("FAIL idle_lock_yumi got=%b exp=0100", yumi_o); end
    edge_step();
    total++; if (v_o !== 1'b1 || tag_o !== 2'd2) begin bad++; $display("FAIL idle_lock_tag got v=%b tag=%0d exp v=1 tag=2", v_o, tag_o); end
  endtask

  task automatic test_backpressure();
    int nx, exp_tag;
    int exp_seq [4];
    logic stalled, xfer;
    logic [31:0] held;
    nx = 0;
    for (int k = 0; k < 4; k++) exp_seq[k] = 0;
    do_reset();
    v_i = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      ready_i = BP_RDY[i];
      #1;
      stalled = v_o & ~ready_i;
      xfer = v_o & ready_i;
      held = data_o;
      if (stalled) begin
        total++; if (yumi_o !== 4'b0000) begin bad++; $display("FAIL bp_stall_yumi[%0d] got=%b exp=0000", i, yumi_o); end
      end
      if (xfer) begin
        exp_tag = (nx / 4) % 4;
        total++;
        if (data_o !== {8'(exp_tag), 24'(exp_seq[exp_tag])} || tag_o !== 2'(exp_tag)) begin
          bad++; $display("FAIL bp_word[%0d] got tag=%0d data=%h exp tag=%0d data=%h", nx, tag_o, data_o, exp_tag, {8'(exp_tag), 24'(exp_seq[exp_tag])});
        end
        exp_seq[exp_tag]++;
        nx++;
      end
      edge_step();
      if (stalled) begin
        total++; if (v_o !== 1'b1 || data_o !== held) begin bad++; $display("FAIL bp_hold[%0d] got v=%b data=%h exp v=1 data=%h", i, v_o, data_o, held); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_tag;
    do_reset();
    v2_i = 4'b1010;
    ready2_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge_step();
      exp_tag = (i % 2 == 0) ? 2'd1 : 2'd3;
      total++;
      if (v2_o !== 1'b1 || tag2_o !== exp_tag || data2_o !== {30'h34, exp_tag}) begin
        bad++; $display("FAIL rr[%0d] got v=%b tag=%0d data=%h exp tag=%0d", i, v2_o, tag2_o, data2_o, exp_tag);
      end
    end
    v2_i = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    ready_i = 1'b1;
    v_i = 4'b0010;
    repeat (3) edge_step();
    total++; if (v_o !== 1'b1 || tag_o !== 2'd1 || data_o !== {8'd1, 24'd2}) begin bad++; $display("FAIL ar_third got v=%b tag=%0d data=%h exp v=1 tag=1 data=01000002", v_o, tag_o, data_o); end
    reset_n_i = 1'b0;
    #1;
    total++; if (v_o !== 1'b0 || yumi_o !== 4'b0000) begin bad++; $display("FAIL ar_drop got v=%b yumi=%b exp v=0 yumi=0000", v_o, yumi_o); end
    for (int k = 0; k < 4; k++) src_seq[k] = 0;
    @(negedge clk);
    reset_n_i = 1'b1;
    v_i = 4'b1111;
    #1;
    total++; if (yumi_o !== 4'b0001) begin bad++; $display("FAIL ar_release_yumi got=%b exp=0001", yumi_o); end
    edge_step();
    total++; if (v_o !== 1'b1 || tag_o !== 2'd0) begin bad++; $display("FAIL ar_regrant got v=%b tag=%0d exp v=1 tag=0", v_o, tag_o); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) src_seq[k] = 0;
    test_reset();
    test_burst();
    test_owner_drop();
    test_idle_lock();
    test_backpressure();
    test_round_robin();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
